// File: rtl/sram_word_controller.sv
// Two-phase controller that splits 32-bit MEM-stage loads/stores into
// low-then-high 16-bit accesses on an asynchronous SRAM.
module sram_word_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic [SRAM_AW-2:0] idx;
  logic [31:0]        data;

  logic               req;
  logic               last;
  logic [SRAM_AW-2:0] idx_next;

  assign req      = rd_en | wr_en;
  assign last     = (cnt == CW'(WAIT_CYCLES - 1));
  // Out-of-range addresses simply wrap into the SRAM word space.
  assign idx_next = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
  assign ready    = ((state == IDLE) && !req) || (state == DONE);

  // The final cycle of each half keeps data and address driven with the
  // write strobe released, giving the SRAM its data hold time.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {idx, (state == HI)};
      if (op_wr) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? data[31:16] : data[15:0];
        sram_we_n   = last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      op_wr     <= 1'b0;
      idx       <= '0;
      data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr <= wr_en;
            idx   <= idx_next;
            data  <= write_data;
            cnt   <= '0;
            state <= LO;
          end
        end
        LO: begin
          if (last) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            cnt   <= '0;
            state <= HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HI: begin
          if (last) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_word_controller.md
Name: sram_word_controller

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM.
- Splits each 32-bit word load (LDR) or store (STR) into two 16-bit SRAM accesses: low half first, then high half.
- Holds `ready` low while an access is in flight; the pipeline uses this as its freeze signal.
- Returns the assembled 32-bit load word to the MEM/WB path.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 3: cycles each 16-bit half-access is held on the SRAM pins. Must be >= 2.
- SRAM_AW, 18: SRAM address width, in 16-bit halfwords.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- rd_en  in  1  load request (mem_r_en from the MEM stage).
- wr_en  in  1  store request (mem_w_en from the MEM stage).
- address  in  32  byte address from the ALU result.
- write_data  in  32  store data.
- read_data  out  32  assembled load data.
- ready  out  1  high = no access pending or access completing this cycle; low = freeze pipeline.
- sram_addr  out  SRAM_AW  halfword address to the SRAM.
- sram_dq_out  out  16  data driven to the SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out.
- sram_dq_in  in  16  data read from the SRAM.
- sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- State machine: IDLE, LO, HI, DONE. Phase counter `cnt` counts 0..WAIT_CYCLES-1.
- Reset (rst==0 at an edge, from any state, including mid-access):
  - state <- IDLE, cnt <- 0, read_data <- 0.
  - Latched op/address/data are cleared to 0.
  - An interrupted store is abandoned; nothing is retried.
- SRAM-side outputs are Moore outputs, decoded from state, cnt and latched registers:
  - In IDLE and DONE: sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- IDLE:
  - If wr_en|rd_en: latch op (wr_en has priority when both are high), word index = (address-BASE_ADDR)>>2, and write_data; go to LO with cnt=0.
  - Otherwise remain in IDLE.
  - The index is truncated to SRAM_AW-1 bits (wrap-around); there is no range check.
- LO:
  - sram_addr = {idx,1'b0}.
  - Store: sram_dq_oe=1, sram_dq_out=data[15:0], sram_we_n=0 for cnt<WAIT_CYCLES-1 and 1 on the final cycle (data hold).
  - Load: sram_dq_oe=0, sram_we_n=1; at the edge ending cnt==WAIT_CYCLES-1, capture read_data[15:0] <- sram_dq_in.
  - Then go to HI with cnt=0.
- HI: identical to LO with sram_addr={idx,1'b1}, data[31:16], and capture into read_data[31:16]. Then go to DONE.
- DONE: lasts exactly one cycle, then IDLE.
- ready (combinational) = (state==IDLE && !(rd_en|wr_en)) || state==DONE.
  - A request freezes the pipeline in the same cycle it appears.
- Latency with the request first seen in cycle 0:
  - LO occupies cycles 1..W, HI occupies W+1..2W, DONE is cycle 2W+1 (cycle 7 for W=3).
  - ready=0 in cycles 0..2W; ready=1 in cycle 2W+1.
- Inputs are sampled only in IDLE. Changes to rd_en, wr_en, address or write_data during LO, HI or DONE are ignored.
- Back-to-back requests: if a request is present in the cycle after DONE (IDLE), a new access starts immediately and ready is low that cycle.
- read_data:
  - Stable and valid from the DONE cycle until the next load's LO capture.
  - Stores never modify read_data.
  - During a load, read_data[31:16] keeps its old value until the HI capture.

Test Plan:
1. Reset: rst=0 for 2 cycles with rd_en=1 -> state IDLE, read_data=0, sram_we_n=1, sram_dq_oe=0; after release, with rd_en=wr_en=0 -> ready=1.
2. Store 0xDEADBEEF to address 1028 (W=3):
   - cycles 1-3: sram_addr=2, sram_dq_out=0xBEEF, oe=1, we_n=0,0,1.
   - cycles 4-6: sram_addr=3, sram_dq_out=0xDEAD, we_n=0,0,1.
   - ready=0 in cycles 0-6, ready=1 in cycle 7.
3. Load from 1028 with an SRAM model holding the step-2 data -> read_data=0xDEADBEEF in cycle 7, ready=1; oe=0 and we_n=1 throughout.
4. Keep rd_en high through DONE into cycle 8 -> new access starts, ready=0 in cycle 8, LO in cycles 9-11; read_data stays 0xDEADBEEF until its cycle-11 capture.
5. rd_en=wr_en=1 at address 1032 with data 0x12345678, and address changed to 2000 in cycle 2 -> write performed to sram_addr 4/5 with 0x5678/0x1234; read_data unchanged.
6. rst=0 at cycle 4 of a store -> next cycle IDLE, we_n=1, oe=0; a subsequent load of 1028 returns the step-2 value.
